// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the multi-cycle divider.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_LATENCY = 34;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports: rem/quo/divisor in, rem_next/quo_next out ({rem,quo} shifted left, trial subtract, quotient bit in LSB).
module div_step import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] trial;
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
  // trial MSB set means the subtraction borrowed: restore the shifted remainder
  assign rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: iterative DIV/DIVU unit producing LO (quotient) and HI (remainder).
// Ports: clk, reset (sync, active-high), start, is_signed (only with DIV_SIGNED_EN),
// dividend, divisor in; busy, done (1-cycle pulse), quotient, remainder, div_by_zero out.
// DIV_SIGNED_EN: adds is_signed, magnitude conversion and sign fixup; otherwise all unsigned.
module mips_div_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);
  div_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_n, quo_n, a_mag, b_mag, q_fix, r_fix;
`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg, a_neg, b_neg;
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
  assign q_fix = q_neg ? -quo : quo;
  // with a zero divisor rem ends as the dividend magnitude, so this also restores the raw dividend
  assign r_fix = r_neg ? -rem : rem;
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = quo;
  assign r_fix = rem;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .quo(quo),
    .divisor(dvsr),
    .rem_next(rem_n),
    .quo_next(quo_n)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvsr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= start ? CALC : IDLE;
          if (start) begin
            busy <= 1'b1;
            cnt <= CW'(WIDTH - 1);
            rem <= '0;
            quo <= a_mag;
            dvsr <= b_mag;
`ifdef DIV_SIGNED_EN
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
`endif
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - CW'(1);
        end
        FIX: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          div_by_zero <= dvsr == '0;
          quotient <= (dvsr == '0) ? '1 : q_fix;
          remainder <= r_fix;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed self-checking bench for mips_div_unit.
module tb_mips_div_unit;
  import div_pkg::*;
  logic clk = 0, reset = 1, start = 0;
`ifdef DIV_SIGNED_EN
  logic is_signed = 0;
`endif
  logic [31:0] dividend = 0, divisor = 0;
  logic busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  int total = 0, fails = 0, cyc = 0, busy_low = 0, done_seen = 0;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
`ifdef DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // called #1 after an edge: start is high for one cycle T, afterwards cyc==1 means T+1
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    dividend = a;
    divisor = b;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    cyc = 1;
  endtask

  task automatic wait_done();
    busy_low = 0;
    while (!done && cyc < 60) begin
      if (!busy) busy_low++;
      step();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] q, input logic [31:0] r, input logic z);
    chk({tag, " latency"}, cyc, DIV_LATENCY);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
    chk({tag, " div_by_zero"}, div_by_zero, z);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic z);
    go(a, b);
    wait_done();
    check(tag, q, r, z);
    step();
  endtask

  initial begin
    repeat (3) step();
    reset = 0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset dbz", div_by_zero, 0);

    go(100, 7);
    wait_done();
    chk("divu busy window", busy_low, 0);
    check("divu 100/7", 14, 2, 0);
    step();
    chk("pulse done low", done, 0);
    chk("held quotient", quotient, 14);

    run("divu max/1", 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 0);
    go(5, 0);
    wait_done();
    check("divu 5/0", 32'hFFFFFFFF, 5, 1);
    step();
    chk("dbz held", div_by_zero, 1);
    chk("dbz rem held", remainder, 5);

`ifdef DIV_SIGNED_EN
    is_signed = 1;
    run("div -7/2", 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
    run("div 7/-2", 7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 0);
    run("div min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    run("div -5/0", 32'hFFFFFFFB, 0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);
    is_signed = 0;
`else
    run("divu F9/2", 32'hFFFFFFF9, 2, 32'h7FFFFFFC, 1, 0);
`endif

    go(100, 7);
    while (cyc < 10) step();
    dividend = 1000;
    divisor = 3;
    start = 1;
    step();
    start = 0;
    wait_done();
    check("ignored start", 14, 2, 0);
    go(1000, 3);
    wait_done();
    check("back-to-back", 333, 1, 0);
    step();

    go(100, 7);
    while (cyc < 15) step();
    reset = 1;
    step();
    reset = 0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort dbz", div_by_zero, 0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      step();
    end
    chk("abort no done", done_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
